// File: rtl/pio_cmd_loader_pkg.sv
// pio_cmd_loader_pkg: shared widths, data_in field offsets and FSM states for the pad-side command loader
package pio_cmd_loader_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    // data_in control bits sit above {idx, payload}; offsets are relative to CHUNK_W+IDX_W
    localparam int IN_LAST_OFS = 0;
    localparam int IN_TOG_OFS  = 1;
    localparam int IN_OP_OFS   = 2;

    function automatic int idx_w(input int nchunk);
        return (nchunk > 2) ? $clog2(nchunk) : 1;
    endfunction

    function automatic int in_w(input int op_w, input int iw, input int chunk_w);
        return op_w + 2 + iw + chunk_w;
    endfunction

    function automatic int out_w(input int res_w, input int st_w);
        return res_w + st_w + 2;
    endfunction

endpackage

// File: rtl/pio_beat_detect.sv
// pio_beat_detect: toggle-strobe beat detector and data_in field splitter
//   clk, rst   : clock, synchronous active-high reset
//   data_i     : packed {op, tog, last, idx, payload} from the pads
//   beat_o     : high while data_i.tog differs from the last sampled toggle
//   op_o, last_o, idx_o, payload_o : unpacked fields of data_i
module pio_beat_detect
    import pio_cmd_loader_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int IDX_W   = 2,
    parameter int OP_W    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [in_w(OP_W, IDX_W, CHUNK_W)-1:0] data_i,
    output logic                                  beat_o,
    output logic                                  last_o,
    output logic [OP_W-1:0]                       op_o,
    output logic [IDX_W-1:0]                      idx_o,
    output logic [CHUNK_W-1:0]                    payload_o
);

    localparam int CTRL = CHUNK_W + IDX_W;

    logic tog_q;

    // Following tog every cycle is equivalent to updating only on a beat.
    always_ff @(posedge clk) begin
        tog_q <= rst ? 1'b0 : data_i[CTRL+IN_TOG_OFS];
    end

    always_comb begin
        beat_o    = data_i[CTRL+IN_TOG_OFS] != tog_q;
        last_o    = data_i[CTRL+IN_LAST_OFS];
        op_o      = data_i[CTRL+IN_OP_OFS +: OP_W];
        idx_o     = data_i[CHUNK_W +: IDX_W];
        payload_o = data_i[CHUNK_W-1:0];
    end

endmodule

// File: rtl/pio_cmd_loader.sv
// pio_cmd_loader: assembles a multi-beat operand from pads, issues it to the core, latches the result
//   clk, rst                : clock, synchronous active-high reset
//   data_in                 : packed {op, tog, last, idx, payload}
//   data_out                : {busy, err, res_status, res_data}
//   cmd_valid/ready/op/data : command handshake towards the core
//   res_valid/data/status   : single-cycle result strobe from the core
module pio_cmd_loader
    import pio_cmd_loader_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int NCHUNK  = 3,
    parameter int OP_W    = 2,
    parameter int RES_W   = 4,
    parameter int ST_W    = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [in_w(OP_W, idx_w(NCHUNK), CHUNK_W)-1:0] data_in,
    output logic [out_w(RES_W, ST_W)-1:0]                 data_out,
    output logic                                          cmd_valid,
    input  logic                                          cmd_ready,
    output logic [OP_W-1:0]                               cmd_op,
    output logic [CHUNK_W*NCHUNK-1:0]                     cmd_data,
    input  logic                                          res_valid,
    input  logic [RES_W-1:0]                              res_data,
    input  logic [ST_W-1:0]                               res_status
);

    localparam int IDX_W  = idx_w(NCHUNK);
    localparam int DATA_W = CHUNK_W * NCHUNK;

    state_e              state_q, state_d;
    logic                beat, last, idx_ok, accept, busy;
    logic [OP_W-1:0]     op;
    logic [IDX_W-1:0]    idx;
    logic [CHUNK_W-1:0]  payload;
    logic [DATA_W-1:0]   shadow_q;
    logic [OP_W-1:0]     op_q;
    logic                err_q;
    logic [RES_W-1:0]    res_data_q;
    logic [ST_W-1:0]     res_status_q;

    pio_beat_detect #(
        .CHUNK_W (CHUNK_W),
        .IDX_W   (IDX_W),
        .OP_W    (OP_W)
    ) u_beat (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_in),
        .beat_o    (beat),
        .last_o    (last),
        .op_o      (op),
        .idx_o     (idx),
        .payload_o (payload)
    );

    // Only beats landing in IDLE with an in-range index touch the shadow.
    assign idx_ok = int'(idx) < NCHUNK;
    assign accept = state_q == IDLE && beat && idx_ok;

    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && last) state_d = ISSUE;
            ISSUE:   if (cmd_ready) state_d = WAIT;
            WAIT:    if (res_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != IDLE;
        cmd_valid = state_q == ISSUE;
        cmd_op    = op_q;
        cmd_data  = shadow_q;
        data_out  = {busy, err_q, res_status_q, res_data_q};
    end

    // Shadow and opcode only change in IDLE, so they stay stable while a command is offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            op_q         <= '0;
            err_q        <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                for (int i = 0; i < NCHUNK; i++)
                    if (int'(idx) == i) shadow_q[i*CHUNK_W +: CHUNK_W] <= payload;
            end
            // Overrun or bad index sets err; a launching beat clears it; other beats leave it.
            if (beat) err_q <= (busy || !idx_ok) ? 1'b1 : (last ? 1'b0 : err_q);
            if (state_q == WAIT && res_valid) begin
                res_data_q   <= res_data;
                res_status_q <= res_status;
            end
        end
    end

endmodule

// File: tb/tb_pio_cmd_loader.sv
// tb_pio_cmd_loader: directed vector table, corner sequences and randomized model check for pio_cmd_loader
module tb_pio_cmd_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] data_in;
    logic [7:0]  data_out;
    logic        cmd_valid, cmd_ready, res_valid;
    logic [1:0]  cmd_op, res_status;
    logic [23:0] cmd_data;
    logic [3:0]  res_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic        tog, last;
        logic [1:0]  idx;
        logic [7:0]  pay;
        logic        rdy, rv;
        logic [3:0]  rd;
        logic [1:0]  rs;
        logic        ev;
        logic [1:0]  eop;
        logic [23:0] edata;
        logic [7:0]  eout;
    } vec_t;

    vec_t tbl[$];

    // Reference model: operand kept as a byte array, progress as two flags.
    bit         m_tog, m_pend, m_wait, m_err;
    logic [7:0] m_chunk[3];
    logic [1:0] m_op, m_st;
    logic [3:0] m_res;

    pio_cmd_loader dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_out   (data_out),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_status (res_status)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [1:0] op, logic tg, logic lst, logic [1:0] ix,
                                logic [7:0] py, logic rdy, logic rv, logic [3:0] rd, logic [1:0] rs,
                                logic ev, logic [1:0] eop, logic [23:0] ed, logic [7:0] eo);
        vec_t v;
        v.rst = r; v.op = op; v.tog = tg; v.last = lst; v.idx = ix; v.pay = py;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.rs = rs;
        v.ev = ev; v.eop = eop; v.edata = ed; v.eout = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Applies one cycle of inputs, advances the model, and returns 1 time unit after the edge.
    task automatic step(input logic r, input logic [1:0] op, input logic tg, input logic lst,
                        input logic [1:0] ix, input logic [7:0] py, input logic rdy, input logic rv,
                        input logic [3:0] rd, input logic [1:0] rs);
        bit b;
        rst = r; data_in = {op, tg, lst, ix, py};
        cmd_ready = rdy; res_valid = rv; res_data = rd; res_status = rs;
        if (r) begin
            m_tog = 0; m_pend = 0; m_wait = 0; m_err = 0; m_op = 0; m_st = 0; m_res = 0;
            foreach (m_chunk[i]) m_chunk[i] = 8'h00;
        end else begin
            b = tg != m_tog;
            m_tog = tg;
            if (m_pend) begin
                if (b) m_err = 1;
                if (rdy) begin m_pend = 0; m_wait = 1; end
            end else if (m_wait) begin
                if (b) m_err = 1;
                if (rv) begin m_res = rd; m_st = rs; m_wait = 0; end
            end else if (b) begin
                if (ix > 2) m_err = 1;
                else begin
                    m_chunk[ix] = py;
                    m_op = op;
                    if (lst) begin m_err = 0; m_pend = 1; end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cmd(input string nm, input logic ev, input logic [1:0] eop,
                           input logic [23:0] ed, input logic [7:0] eo);
        chk({nm, "_valid"}, cmd_valid, ev);
        chk({nm, "_out"}, data_out, eo);
        if (ev) begin
            chk({nm, "_op"}, cmd_op, eop);
            chk({nm, "_data"}, cmd_data, ed);
        end
    endtask

    initial begin
        logic tg;
        // rst op tog last idx pay rdy rv rd rs | ev eop data out
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 24'h0, 8'h00));
        tbl.push_back(mk(0, 2, 1, 0, 0, 8'h11, 1, 0, 0, 0, 0, 0, 24'h0, 8'h00));
        tbl.push_back(mk(0, 2, 0, 0, 1, 8'h22, 1, 0, 0, 0, 0, 0, 24'h0, 8'h00));
        tbl.push_back(mk(0, 2, 1, 1, 2, 8'h33, 1, 0, 0, 0, 1, 2, 24'h332211, 8'h80));
        tbl.push_back(mk(0, 2, 1, 1, 2, 8'h33, 1, 0, 0, 0, 0, 0, 24'h0, 8'h80));
        tbl.push_back(mk(0, 2, 1, 1, 2, 8'h33, 1, 1, 4'hA, 1, 0, 0, 24'h0, 8'h1A));
        tbl.push_back(mk(0, 2, 1, 1, 2, 8'h33, 1, 1, 4'h5, 2, 0, 0, 24'h0, 8'h1A));
        tbl.push_back(mk(0, 1, 0, 1, 3, 8'h77, 1, 0, 0, 0, 0, 0, 24'h0, 8'h5A));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 0, 1, 3, 8'h77, 1, 0, 0, 0, 0, 0, 24'h0, 8'h5A));
        tbl.push_back(mk(0, 3, 1, 1, 1, 8'h55, 0, 0, 0, 0, 1, 3, 24'h335511, 8'h9A));
        tbl.push_back(mk(0, 3, 1, 1, 1, 8'h55, 1, 0, 0, 0, 0, 0, 24'h0, 8'h9A));
        tbl.push_back(mk(0, 3, 1, 1, 1, 8'h55, 1, 1, 4'h3, 2, 0, 0, 24'h0, 8'h23));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].op, tbl[i].tog, tbl[i].last, tbl[i].idx, tbl[i].pay,
                 tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].rs);
            chk_cmd($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eop, tbl[i].edata, tbl[i].eout);
        end

        // Backpressure: five stalled cycles with an overrun beat in the middle.
        step(0, 1, 0, 1, 0, 8'hAA, 0, 0, 0, 0);
        chk_cmd("bp_launch", 1, 1, 24'h3355AA, 8'hA3);
        for (int k = 0; k < 5; k++) begin
            tg = (k >= 2);
            step(0, 1, tg, 1, 2, 8'hEE, 0, 0, 0, 0);
            chk_cmd($sformatf("bp_stall%0d", k), 1, 1, 24'h3355AA, (k >= 2) ? 8'hE3 : 8'hA3);
        end
        // Beat coinciding with cmd_ready: overrun, yet the handshake completes.
        step(0, 1, 0, 1, 2, 8'hEE, 1, 0, 0, 0);
        chk_cmd("bp_accept", 0, 0, 24'h0, 8'hE3);
        step(0, 1, 0, 1, 2, 8'hEE, 1, 1, 4'hF, 3);
        chk_cmd("bp_result", 0, 0, 24'h0, 8'h7F);
        // Relaunch shows the stalled beat never reached chunk 2.
        step(0, 0, 1, 1, 0, 8'h99, 0, 0, 0, 0);
        chk_cmd("bp_shadow", 1, 0, 24'h335599, 8'hBF);
        step(0, 0, 1, 1, 0, 8'h99, 1, 0, 0, 0);
        chk_cmd("rw_wait", 0, 0, 24'h0, 8'hBF);

        // Reset while waiting for the core.
        step(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        chk_cmd("rw_reset", 0, 0, 24'h0, 8'h00);
        chk("rw_reset_data", cmd_data, 24'h0);
        chk("rw_reset_op", cmd_op, 2'd0);
        step(0, 1, 0, 1, 0, 8'h44, 1, 0, 0, 0);
        chk_cmd("rw_tog0", 0, 0, 24'h0, 8'h00);
        step(0, 1, 1, 1, 0, 8'h44, 0, 0, 0, 0);
        chk_cmd("rw_tog1", 1, 1, 24'h000044, 8'h80);

        // Randomized traffic against the model.
        step(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            tg = ($urandom_range(0, 2) == 0) ? ~m_tog : m_tog;
            step($urandom_range(0, 199) == 0, 2'($urandom), tg, 1'($urandom), 2'($urandom),
                 8'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 4'($urandom), 2'($urandom));
            chk_cmd($sformatf("rnd%0d", n), m_pend, m_op, {m_chunk[2], m_chunk[1], m_chunk[0]},
                    {m_pend | m_wait, m_err, m_st, m_res});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
